// File: rtl/dragonfang_pkg.sv
// Shared types and constants for the vector write-back path.
// Holds the register tag width, data width, the default requester count,
// the scheduler state encoding, and the result/control packet types that
// the write-back stages exchange.
package dragonfang_pkg;

  localparam int TAG_WIDTH       = 5;
  localparam int DATA_W          = 64;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_READ  = 2'd1,
    SCH_LATCH = 2'd2,
    SCH_WRITE = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    BIT_MODE_8  = 2'd0,
    BIT_MODE_16 = 2'd1,
    BIT_MODE_32 = 2'd2,
    BIT_MODE_64 = 2'd3
  } bit_mode_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [DATA_W-1:0]    data;
  } data_packet_t;

  typedef struct packed {
    bit_mode_t bit_mode;
    logic      vm;
    logic      vma;
    logic      vta;
  } write_back_vector_t;

endpackage

// File: rtl/vector_write_back_scheduler_if.sv
// Handshake bundle between the write-back scheduler and the
// vector_write_back stage.
//   wb_valid          : scheduler has a complete operand set
//   wb_ready          : write-back stage accepts it
//   write_back_vector : bit_mode/vm/vma/vta for the result
//   vd_new/vd_old/v0  : new result, old destination contents, mask register
interface vector_write_back_scheduler_if;
  import dragonfang_pkg::*;

  logic               wb_valid;
  logic               wb_ready;
  write_back_vector_t write_back_vector;
  data_packet_t       vd_new;
  data_packet_t       vd_old;
  data_packet_t       v0;

  modport master (
    output wb_valid, write_back_vector, vd_new, vd_old, v0,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, write_back_vector, vd_new, vd_old, v0,
    output wb_ready
  );

endinterface

// File: rtl/vector_write_back_scheduler_round_robin_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr and grants
// the first set bit found, wrapping around.
//   req       : request vector
//   ptr       : index that has highest priority this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
//   valid     : some request was granted
module round_robin_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vector_write_back_scheduler.sv
// Vector write-back scheduler. Picks one finished result per transaction
// from the requesters (ALU, MUL, DIV, LSU order) round-robin, reads the old
// destination register and v0 from the register file, and presents the
// complete operand set to the vector_write_back stage.
//   clock, reset_n       : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready one-hot, IDLE only)
//   req_vd_new           : per-requester result, tag = destination register
//   req_wb_ctrl          : per-requester bit_mode/vm/vma/vta
//   rf_rd_en/rf_rd_addr  : register-file read of the destination register
//   rf_rd_vd_old/_v0     : read data, valid the cycle after rf_rd_en
//   wb                   : handshake and registered operands to write-back
// Flow: IDLE (grant) -> READ (rf strobe) -> LATCH (capture rf data)
//       -> WRITE (hold until wb_ready) -> IDLE.
module vector_write_back_scheduler
  import dragonfang_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  data_packet_t [NUM_REQ-1:0]   req_vd_new,
  input  write_back_vector_t [NUM_REQ-1:0] req_wb_ctrl,
  output logic                         rf_rd_en,
  output logic [TAG_WIDTH-1:0]         rf_rd_addr,
  input  data_packet_t                 rf_rd_vd_old,
  input  data_packet_t                 rf_rd_v0,
  vector_write_back_scheduler_if.master wb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               take;
  logic               wb_valid_c;

  data_packet_t       vd_new_q;
  data_packet_t       vd_old_q;
  data_packet_t       v0_q;
  write_back_vector_t ctrl_q;

  round_robin_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= SCH_IDLE;
    else          state_q <= state_d;
  end

  // req_ready is qualified with reset_n so nothing is offered upstream while
  // the block is held in reset, even though the state already reads IDLE.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rf_rd_en   = 1'b0;
    wb_valid_c = 1'b0;
    take       = 1'b0;
    unique case (state_q)
      SCH_IDLE: begin
        if (arb_valid && reset_n) begin
          req_ready = arb_grant;
          take      = 1'b1;
          state_d   = SCH_READ;
        end
      end
      SCH_READ: begin
        rf_rd_en = 1'b1;
        state_d  = SCH_LATCH;
      end
      SCH_LATCH: begin
        state_d = SCH_WRITE;
      end
      SCH_WRITE: begin
        wb_valid_c = 1'b1;
        if (wb.wb_ready) state_d = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end
  end

  // Operand registers. vd_new/ctrl are captured at grant and then held
  // until the next grant, so they stay stable through any WRITE stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vd_new_q <= '0;
      ctrl_q   <= '0;
      vd_old_q <= '0;
      v0_q     <= '0;
    end else begin
      if (take) begin
        vd_new_q <= req_vd_new[arb_idx];
        ctrl_q   <= req_wb_ctrl[arb_idx];
      end
      if (state_q == SCH_LATCH) begin
        vd_old_q <= rf_rd_vd_old;
        v0_q     <= rf_rd_v0;
      end
    end
  end

  assign rf_rd_addr           = vd_new_q.tag;
  assign wb.wb_valid          = wb_valid_c;
  assign wb.write_back_vector = ctrl_q;
  assign wb.vd_new            = vd_new_q;
  assign wb.vd_old            = vd_old_q;
  assign wb.v0                = v0_q;

endmodule

// File: tb/tb_vector_write_back_scheduler.sv
// Directed testbench for vector_write_back_scheduler: reset state, single
// request timing, round-robin fairness, pointer skip, WRITE stall, dropped
// non-granted requests, reset in LATCH, and randomized operand transfer.
module tb_vector_write_back_scheduler;
  import dragonfang_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [3:0]             req_valid;
  logic [3:0]             req_ready;
  data_packet_t [3:0]     req_vd_new;
  write_back_vector_t [3:0] req_wb_ctrl;
  logic                   rf_rd_en;
  logic [TAG_WIDTH-1:0]   rf_rd_addr;
  data_packet_t           rf_rd_vd_old;
  data_packet_t           rf_rd_v0;

  vector_write_back_scheduler_if wbi ();

  vector_write_back_scheduler #(.NUM_REQ(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vd_new   (req_vd_new),
    .req_wb_ctrl  (req_wb_ctrl),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_vd_old (rf_rd_vd_old),
    .rf_rd_v0     (rf_rd_v0),
    .wb           (wbi)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < 4; i++) begin
      req_vd_new[i].tag           = 5'($urandom());
      req_vd_new[i].data          = {$urandom(), $urandom()};
      req_wb_ctrl[i].bit_mode     = bit_mode_t'(2'($urandom()));
      req_wb_ctrl[i].vm           = 1'($urandom());
      req_wb_ctrl[i].vma          = 1'($urandom());
      req_wb_ctrl[i].vta          = 1'($urandom());
    end
  endtask

  function automatic int rr_pick(input logic [3:0] rv, input int ptr);
    for (int off = 0; off < 4; off++) begin
      if (rv[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_txn(input string nm, input logic [3:0] rv, input logic [3:0] rv_after,
                         input int exp_idx, input int stall);
    data_packet_t       e_new, e_old, e_v0;
    write_back_vector_t e_ctrl;
    logic [3:0]         e_gnt;
    e_gnt        = 4'(1 << exp_idx);
    wbi.wb_ready = (stall == 0);
    req_valid    = rv;
    #1;
    chk({nm, ":req_ready"}, 256'(req_ready), 256'(e_gnt));
    e_new  = req_vd_new[exp_idx];
    e_ctrl = req_wb_ctrl[exp_idx];
    tick();  // READ
    req_valid = rv_after;
    req_vd_new[exp_idx].data = ~e_new.data;
    m_ptr = (exp_idx + 1) % 4;
    #1;
    chk({nm, ":rd_en"}, 256'(rf_rd_en), 256'(1'b1));
    chk({nm, ":rd_addr"}, 256'(rf_rd_addr), 256'(e_new.tag));
    chk({nm, ":ready_busy"}, 256'(req_ready), 256'(4'b0000));
    chk({nm, ":rr_ptr"}, 256'(dut.rr_ptr), 256'(m_ptr));
    tick();  // LATCH
    e_old.tag  = 5'($urandom());
    e_old.data = {$urandom(), $urandom()};
    e_v0.tag   = 5'($urandom());
    e_v0.data  = {$urandom(), $urandom()};
    rf_rd_vd_old = e_old;
    rf_rd_v0     = e_v0;
    #1;
    chk({nm, ":rd_en_latch"}, 256'(rf_rd_en), 256'(1'b0));
    chk({nm, ":wb_valid_latch"}, 256'(wbi.wb_valid), 256'(1'b0));
    tick();  // WRITE
    rf_rd_vd_old = '0;
    rf_rd_v0     = '0;
    #1;
    chk({nm, ":wb_valid"}, 256'(wbi.wb_valid), 256'(1'b1));
    chk({nm, ":rd_en_write"}, 256'(rf_rd_en), 256'(1'b0));
    chk({nm, ":vd_new"}, 256'(wbi.vd_new), 256'(e_new));
    chk({nm, ":vd_old"}, 256'(wbi.vd_old), 256'(e_old));
    chk({nm, ":v0"}, 256'(wbi.v0), 256'(e_v0));
    chk({nm, ":wb_ctrl"}, 256'(wbi.write_back_vector), 256'(e_ctrl));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({nm, ":stall_valid"}, 256'(wbi.wb_valid), 256'(1'b1));
      chk({nm, ":stall_ready"}, 256'(req_ready), 256'(4'b0000));
      chk({nm, ":stall_hold"}, 256'({wbi.vd_new, wbi.vd_old, wbi.write_back_vector}),
          256'({e_new, e_old, e_ctrl}));
      chk({nm, ":stall_v0"}, 256'(wbi.v0), 256'(e_v0));
    end
    wbi.wb_ready = 1'b1;
    tick();  // back in IDLE
    chk({nm, ":wb_valid_idle"}, 256'(wbi.wb_valid), 256'(1'b0));
    chk({nm, ":state_idle"}, 256'(dut.state_q), 256'(SCH_IDLE));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_ptr   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rv;
    int         e;
    reset_n      = 1'b0;
    req_valid    = 4'b1111;
    req_vd_new   = '0;
    req_wb_ctrl  = '0;
    rf_rd_vd_old = '0;
    rf_rd_v0     = '0;
    wbi.wb_ready = 1'b1;
    randomize_reqs();
    tick();
    tick();
    // Held in reset with all requests up.
    chk("rst:req_ready", 256'(req_ready), 256'(4'b0000));
    chk("rst:wb_valid", 256'(wbi.wb_valid), 256'(1'b0));
    chk("rst:rd_en", 256'(rf_rd_en), 256'(1'b0));
    chk("rst:data", 256'({wbi.vd_new, wbi.vd_old, wbi.write_back_vector}), 256'(0));
    chk("rst:v0", 256'(wbi.v0), 256'(0));
    chk("rst:rr_ptr", 256'(dut.rr_ptr), 256'(0));
    chk("rst:state", 256'(dut.state_q), 256'(SCH_IDLE));
    req_valid = 4'b0000;
    reset_n   = 1'b1;
    #1;
    chk("rst:no_req", 256'(req_ready), 256'(4'b0000));

    // Single request from requester 0, destination register 5.
    req_vd_new[0].tag  = 5'd5;
    req_vd_new[0].data = 64'h0123_4567_89ab_cdef;
    req_wb_ctrl[0]     = '{bit_mode: BIT_MODE_32, vm: 1'b1, vma: 1'b0, vta: 1'b1};
    run_txn("single", 4'b0001, 4'b0000, 0, 0);

    // Fairness from a fresh pointer: 0,1,2,3,0 with all requests held.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      randomize_reqs();
      run_txn("fair", 4'b1111, 4'b1111, k % 4, 0);
    end

    // Pointer skip: grant 1, then only requester 0 asks.
    run_txn("skip_a", 4'b0010, 4'b0000, 1, 0);
    run_txn("skip_b", 4'b0001, 4'b0000, 0, 0);

    // Back-pressure for 10 cycles in WRITE.
    randomize_reqs();
    run_txn("stall", 4'b0100, 4'b0000, 2, 10);

    // Non-granted requesters drop while the grant is in flight.
    randomize_reqs();
    run_txn("drop", 4'b1011, 4'b0001, 3, 0);
    run_txn("after_drop", 4'b0001, 4'b0000, 0, 0);

    // Reset asserted while in LATCH.
    randomize_reqs();
    req_valid = 4'b0100;
    #1;
    chk("midrst:grant", 256'(req_ready), 256'(4'b0100));
    tick();
    req_valid = 4'b0000;
    tick();
    chk("midrst:in_latch", 256'(dut.state_q), 256'(SCH_LATCH));
    reset_n = 1'b0;
    #1;
    chk("midrst:wb_valid", 256'(wbi.wb_valid), 256'(1'b0));
    chk("midrst:rd_en", 256'(rf_rd_en), 256'(1'b0));
    chk("midrst:state", 256'(dut.state_q), 256'(SCH_IDLE));
    chk("midrst:rr_ptr", 256'(dut.rr_ptr), 256'(0));
    chk("midrst:vd_new", 256'(wbi.vd_new), 256'(0));
    tick();
    reset_n = 1'b1;
    m_ptr   = 0;
    run_txn("post_rst", 4'b1111, 4'b0000, 0, 0);

    // Randomized operands, modes and request patterns.
    for (int n = 0; n < 8; n++) begin
      randomize_reqs();
      rv = 4'($urandom_range(1, 15));
      e  = rr_pick(rv, m_ptr);
      run_txn("rand", rv, rv, e, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_write_back_scheduler.md
VECTOR_WRITE_BACK_SCHEDULER -- requirements
Module: vector_write_back_scheduler

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of result requesters (ALU, MUL, DIV, LSU order).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  NUM_REQ  per-requester result valid.
REQ-005 SHALL have port: req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-006 SHALL have port: req_vd_new  input  NUM_REQ x data_packet_t  result data; tag = destination register.
REQ-007 SHALL have port: req_wb_ctrl  input  NUM_REQ x write_back_vector_t  bit_mode/vm/vma/vta per result.
REQ-008 SHALL have port: rf_rd_en  output  1  register-file read strobe.
REQ-009 SHALL have port: rf_rd_addr  output  TAG_WIDTH  register to read as vd_old.
REQ-010 SHALL have port: rf_rd_vd_old, rf_rd_v0  input  data_packet_t each  read data, valid the cycle after rf_rd_en.
REQ-011 SHALL have port: wb_valid / wb_ready  output / input  1 / 1  handshake to vector_write_back stage.
REQ-012 SHALL have port: write_back_vector, vd_new, vd_old, v0  output  write_back_vector_t / data_packet_t x3  registered operands for vector_write_back.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> LATCH -> WRITE -> IDLE.
REQ-014 In IDLE, with any req_valid set, SHALL assert req_ready for exactly one requester, chosen round-robin from pointer rr_ptr, and capture its vd_new/wb_ctrl; next state READ.
REQ-015 SHALL drive req_ready combinationally only in IDLE; req_ready = 0 in all other states.
REQ-016 After grant to index i, rr_ptr SHALL become (i+1) mod NUM_REQ; rr_ptr unchanged when no grant.
REQ-017 READ: rf_rd_en = 1 for one cycle, rf_rd_addr = captured vd_new.tag; next state LATCH.
REQ-018 LATCH: SHALL register rf_rd_vd_old into vd_old and rf_rd_v0 into v0; next state WRITE.
REQ-019 WRITE: wb_valid = 1; outputs held stable until wb_valid && wb_ready; then IDLE.
REQ-020 Latency: accept in cycle N -> wb_valid first high in cycle N+3; minimum issue interval 4 cycles.
REQ-021 wb_ready ignored outside WRITE; wb_ready low holds WRITE indefinitely with no output change.
REQ-022 req_valid deasserted by a non-granted requester SHALL not affect state; no request is dropped except on reset.
REQ-023 rf_rd_en SHALL be 0 in IDLE, LATCH, WRITE.

Reset
REQ-024 On reset_n low, at any state, SHALL go to IDLE, rr_ptr = 0, wb_valid = 0, rf_rd_en = 0, req_ready = 0, all data outputs '0.
REQ-025 An accepted but not yet written request SHALL be discarded on reset; upstream flushes concurrently.

Structure
REQ-026 NUM_REQ default, scheduler state enum, and TAG_WIDTH SHALL live in dragonfang_pkg; data_packet_t and write_back_vector_t reused unchanged.
REQ-027 SHALL contain one sub-module round_robin_arbiter (req vector, pointer in; one-hot grant, grant index out).

Verification
REQ-028 Single request: req_valid=4'b0001, tag=5, wb_ready=1 -> req_ready[0] cycle 0, rf_rd_addr=5 cycle 1, wb_valid cycle 3 with vd_new from requester 0.
REQ-029 Fairness: req_valid=4'b1111 held -> grants in order 0,1,2,3,0, every 4 cycles.
REQ-030 Pointer skip: after grant 1, req_valid=4'b0001 -> grant 0; rr_ptr = 1.
REQ-031 Stall: wb_ready=0 for 10 cycles in WRITE -> wb_valid and all outputs constant, req_ready=0; wb_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-op: reset_n pulled low in LATCH -> immediate wb_valid=0, rf_rd_en=0, state IDLE, next grant to requester 0.
REQ-033 Data check: random bit_mode 8/16/32/64, vm/vma/vta, rf data -> outputs match captured values bit-exact at wb handshake.
